// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN (fixed priority, requester 0 wins).
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam int REQ_CPU  = 0;
    localparam int REQ_HOST = 1;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way tie-break: one-hot grant from a request pair and the last winner.
// On a tie the requester that did not win last time is chosen.
module arb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a 1-cycle-latency single-port data RAM.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins ties).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_wr,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic              r1_req,
    input  logic              r1_wr,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r0_gnt,
    output logic              r1_gnt,
    output logic              r0_rvalid,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              mem_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t     r_state;
    logic [1:0] r_rvalid;
    logic       w_idle;
    logic       w_last;
    logic       w_rd_gnt;
    logic [1:0] w_req;
    logic [1:0] w_gnt;

    // Grants are gated by reset so nothing reaches the RAM while held in reset.
    assign w_idle = reset && (r_state == IDLE);
    assign w_req  = {r1_req, r0_req} & {2{w_idle}};

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_last = 1'b1;
`else
    logic r_last;

    assign w_last = r_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (|w_gnt) begin
            r_last <= w_gnt[REQ_HOST];
        end
    end
`endif

    arb_rr_pick u_pick (
        .req  (w_req),
        .last (w_last),
        .gnt  (w_gnt)
    );

    always_comb begin
        mem_en    = |w_gnt;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            w_gnt[REQ_CPU]: begin
                mem_wr    = r0_wr;
                mem_addr  = r0_addr;
                mem_wdata = r0_wdata;
            end
            w_gnt[REQ_HOST]: begin
                mem_wr    = r1_wr;
                mem_addr  = r1_addr;
                mem_wdata = r1_wdata;
            end
            default: ;
        endcase
    end

    assign w_rd_gnt = mem_en & ~mem_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_rvalid <= 2'b00;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_rd_gnt) begin
                        r_state  <= RD_WAIT;
                        r_rvalid <= w_gnt;
                    end
                end
                RD_WAIT: begin
                    r_state  <= IDLE;
                    r_rvalid <= 2'b00;
                end
            endcase
        end
    end

    assign r0_gnt    = w_gnt[REQ_CPU];
    assign r1_gnt    = w_gnt[REQ_HOST];
    assign r0_rvalid = r_rvalid[REQ_CPU];
    assign r1_rvalid = r_rvalid[REQ_HOST];
    assign rdata     = (r_state == RD_WAIT) ? mem_rdata : '0;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a RAM model and a read scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          r0_req = 1'b0, r0_wr = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r1_req = 1'b0, r1_wr = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy;
    logic [DW-1:0] rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_wr, mem_en;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] ram    [256];
    logic [DW-1:0] shadow [256];
    int            n_chk = 0;
    int            n_fail = 0;
    int            exp_last = 1;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
        .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_en(mem_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    // Read returns are popped from the scoreboard as they appear.
    always @(negedge clk) begin
        if (reset && (r0_rvalid || r1_rvalid)) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rvalid: r0=%0b r1=%0b rdata=%h, none pending",
                         r0_rvalid, r1_rvalid, rdata);
            end else begin
                mon_e = sb.pop_front();
                if ({r0_rvalid, r1_rvalid, rdata} !==
                    {mon_e.who == 0, mon_e.who == 1, mon_e.data}) begin
                    n_fail++;
                    $display("FAIL rvalid_data: got r0=%0b r1=%0b d=%h want who=%0d d=%h",
                             r0_rvalid, r1_rvalid, rdata, mon_e.who, mon_e.data);
                end
            end
        end
    end

    function automatic int pick(input logic q0, input logic q1);
        if (q0 && !q1) return 0;
        if (q1 && !q0) return 1;
        if (!q0 && !q1) return -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (exp_last == 1) ? 0 : 1;
`endif
    endfunction

    task automatic drive(input int who, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (who == 0) begin
            r0_req = 1'b1; r0_wr = wr; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = 1'b1; r1_wr = wr; r1_addr = a; r1_wdata = d;
        end
    endtask

    task automatic drop(input int who);
        if (who == 0) begin
            r0_req = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0;
        end else begin
            r1_req = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0;
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 8'd7, 16'h0BAD);
        drive(1, 1'b0, 8'd9, 16'h0000);
        #12;
        n_chk++;
        if ({r0_gnt, r1_gnt, mem_en, mem_wr, busy, r0_rvalid, r1_rvalid, mem_addr}
            !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt=%b%b en=%b wr=%b busy=%b rv=%b%b addr=%h want 0",
                     r0_gnt, r1_gnt, mem_en, mem_wr, busy, r0_rvalid, r1_rvalid, mem_addr);
        end
        drop(0);
        drop(1);
        @(negedge clk);
        reset = 1'b1;
        exp_last = 1;
    endtask

    task automatic test_tie_after_reset();
        @(posedge clk); #1;
        drive(0, 1'b1, 8'd1, 16'hAAAA);
        drive(1, 1'b1, 8'd2, 16'h5555);
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, r1_gnt, mem_addr} !== {2'b10, 8'd1}) begin
            n_fail++;
            $display("FAIL first_tie: gnt=%b%b addr=%0d want gnt=10 addr=1",
                     r0_gnt, r1_gnt, mem_addr);
        end
        shadow[1] = 16'hAAAA;
        exp_last = 0;
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, r1_gnt, mem_wr, mem_addr, mem_wdata} !== {3'b011, 8'd2, 16'h5555}) begin
            n_fail++;
            $display("FAIL held_r1_write: gnt=%b%b wr=%b addr=%0d wd=%h want 01 1 2 5555",
                     r0_gnt, r1_gnt, mem_wr, mem_addr, mem_wdata);
        end
        shadow[2] = 16'h5555;
        exp_last = 1;
        @(posedge clk); #1;
        drop(1);
    endtask

    task automatic test_write();
        @(posedge clk); #1;
        drive(0, 1'b1, 8'd205, 16'h1234);
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, r1_gnt, mem_en, mem_wr, mem_addr, mem_wdata, r0_rvalid}
            !== {4'b1011, 8'd205, 16'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL write_grant: gnt=%b%b en=%b wr=%b addr=%0d wd=%h rv=%b",
                     r0_gnt, r1_gnt, mem_en, mem_wr, mem_addr, mem_wdata, r0_rvalid);
        end
        shadow[205] = 16'h1234;
        exp_last = 0;
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        n_chk++;
        if ({busy, r0_rvalid, r1_rvalid, mem_en, mem_wr, mem_addr, mem_wdata} !== 29'd0) begin
            n_fail++;
            $display("FAIL idle_after_write: busy=%b rv=%b%b en=%b wr=%b addr=%h wd=%h want 0",
                     busy, r0_rvalid, r1_rvalid, mem_en, mem_wr, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_read();
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd205, 16'h0);
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, r1_gnt, mem_en, mem_wr, mem_addr} !== {4'b1010, 8'd205}) begin
            n_fail++;
            $display("FAIL read_grant: gnt=%b%b en=%b wr=%b addr=%0d want 1010 205",
                     r0_gnt, r1_gnt, mem_en, mem_wr, mem_addr);
        end
        sb.push_back('{0, shadow[205]});
        exp_last = 0;
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        n_chk++;
        if ({busy, r0_rvalid, r1_rvalid, mem_en, rdata} !== {4'b1100, 16'h1234}) begin
            n_fail++;
            $display("FAIL read_return: busy=%b rv=%b%b en=%b rdata=%h want 1100 1234",
                     busy, r0_rvalid, r1_rvalid, mem_en, rdata);
        end
        @(negedge clk);
        n_chk++;
        if ({busy, r0_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL read_done: busy=%b rv=%b want 00", busy, r0_rvalid);
        end
    endtask

    task automatic test_round_robin();
        int w;
        logic exp_grant_cycle;
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd1, 16'h0);
        drive(1, 1'b0, 8'd2, 16'h0);
        exp_grant_cycle = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_chk++;
            if (exp_grant_cycle) begin
                w = pick(1'b1, 1'b1);
                if ({r0_gnt, r1_gnt, mem_en, mem_addr} !==
                    {w == 0, w == 1, 1'b1, (w == 1) ? 8'd2 : 8'd1}) begin
                    n_fail++;
                    $display("FAIL rr_grant[%0d]: gnt=%b%b en=%b addr=%0d want winner %0d",
                             k, r0_gnt, r1_gnt, mem_en, mem_addr, w);
                end
                sb.push_back('{w, shadow[(w == 1) ? 2 : 1]});
                exp_last = w;
            end else if ({r0_gnt, r1_gnt, busy, mem_en} !== 4'b0010) begin
                n_fail++;
                $display("FAIL rr_wait[%0d]: gnt=%b%b busy=%b en=%b want 0010",
                         k, r0_gnt, r1_gnt, busy, mem_en);
            end
            exp_grant_cycle = ~exp_grant_cycle;
        end
        @(posedge clk); #1;
        drop(0);
        drop(1);
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, AW'(i), DW'(16'hB000 + i));
            @(negedge clk);
            n_chk++;
            if ({r1_gnt, r0_gnt, mem_en, mem_wr, mem_addr, mem_wdata} !==
                {4'b1011, AW'(i), DW'(16'hB000 + i)}) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: gnt1=%b en=%b wr=%b addr=%0d wd=%h",
                         i, r1_gnt, mem_en, mem_wr, mem_addr, mem_wdata);
            end
            shadow[i] = DW'(16'hB000 + i);
            exp_last = 1;
            @(posedge clk); #1;
        end
        drop(1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, AW'(i), 16'h0);
            @(negedge clk);
            n_chk++;
            if (r0_gnt !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_readback_grant[%0d]: gnt=%b want 1", i, r0_gnt);
            end
            sb.push_back('{0, shadow[i]});
            exp_last = 0;
            @(posedge clk); #1;
            drop(0);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_rd_wait();
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd205, 16'h0);
        @(negedge clk);
        n_chk++;
        if (r0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_rd_grant: gnt=%b want 1", r0_gnt);
        end
        @(posedge clk); #1;
        drop(0);
        n_chk++;
        if ({busy, r0_rvalid} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_rd_wait_entry: busy=%b rv=%b want 11", busy, r0_rvalid);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if ({r0_rvalid, r1_rvalid, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_drop_rvalid: rv=%b%b busy=%b want 000",
                     r0_rvalid, r1_rvalid, busy);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_last = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if ({r0_rvalid, r1_rvalid, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL rst_no_late_return[%0d]: rv=%b%b busy=%b want 000",
                         k, r0_rvalid, r1_rvalid, busy);
            end
        end
    endtask

    task automatic test_addr_255();
        @(posedge clk); #1;
        drive(0, 1'b1, 8'd255, 16'hFFFF);
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, mem_wr, mem_addr, mem_wdata} !== {2'b11, 8'd255, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL top_addr_write: gnt=%b wr=%b addr=%0d wd=%h want 1 1 255 ffff",
                     r0_gnt, mem_wr, mem_addr, mem_wdata);
        end
        shadow[255] = 16'hFFFF;
        exp_last = 0;
        @(posedge clk); #1;
        drive(0, 1'b0, 8'd255, 16'h0);
        @(negedge clk);
        n_chk++;
        if ({r0_gnt, mem_wr, mem_addr} !== {2'b10, 8'd255}) begin
            n_fail++;
            $display("FAIL top_addr_read: gnt=%b wr=%b addr=%0d want 1 0 255",
                     r0_gnt, mem_wr, mem_addr);
        end
        sb.push_back('{0, shadow[255]});
        @(posedge clk); #1;
        drop(0);
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = '0;
            shadow[i] = '0;
        end
        test_reset();
        test_tie_after_reset();
        test_write();
        test_read();
        test_round_robin();
        test_back_to_back();
        test_reset_in_rd_wait();
        test_addr_255();
        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d reads never returned, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
